// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared types and defaults for the ECC domain-transfer arbiter
package ecc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } dt_state_t;

    localparam int W_DEFAULT       = 32;
    localparam int DT_LATENCY      = 34;
    localparam int TIMEOUT_DEFAULT = 64;

    // Index width never collapses to zero, so NREQ=1 still has a usable index bus.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector: first set req at or after rr_ptr
module rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int k;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            if (!valid && req[k]) begin
                valid  = 1'b1;
                gnt[k] = 1'b1;
                idx    = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/dt_arbiter.sv
// rtl/dt_arbiter.sv - round-robin sharing of one Domain_Transfer converter with done-edge and watchdog
module dt_arbiter
    import ecc_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int W       = W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int IDX_W   = idx_width(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] req_tomont,
    input  logic [NREQ*W-1:0] req_px,
    input  logic [NREQ*W-1:0] req_py,
    input  logic [W-1:0]    prime,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] resp_valid,
    output logic            resp_err,
    output logic [W-1:0]    resp_px,
    output logic [W-1:0]    resp_py,
    output logic            dt_in_sig,
    output logic            dt_tomont,
    output logic [W-1:0]    dt_px,
    output logic [W-1:0]    dt_py,
    output logic [W-1:0]    dt_prime,
    input  logic [W-1:0]    dt_px_out,
    input  logic [W-1:0]    dt_py_out,
    input  logic            dt_done
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    dt_state_t        state;
    dt_state_t        state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] idx_q;
    logic [NREQ-1:0]  gnt_q;
    logic [CNT_W-1:0] cnt;
    logic             done_q;
    logic [W-1:0]     hold_px;
    logic [W-1:0]     hold_py;
    logic [W-1:0]     hold_prime;
    logic             hold_tm;
    logic [W-1:0]     resp_px_q;
    logic [W-1:0]     resp_py_q;
    logic             resp_err_q;

    logic [NREQ-1:0]  pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [W-1:0]     sel_px;
    logic [W-1:0]     sel_py;
    logic             sel_tm;
    logic             done_edge;
    logic             timeout_hit;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .gnt    (pick_gnt),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        sel_px = '0;
        sel_py = '0;
        sel_tm = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_px = req_px[i*W +: W];
                sel_py = req_py[i*W +: W];
                sel_tm = req_tomont[i];
            end
        end
    end

    // A done level carried over from the previous operation is not a completion.
    assign done_edge   = dt_done & ~done_q;
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = BUSY;
            BUSY:    if (done_edge || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            idx_q      <= '0;
            gnt_q      <= '0;
            cnt        <= '0;
            done_q     <= 1'b0;
            hold_px    <= '0;
            hold_py    <= '0;
            hold_prime <= '0;
            hold_tm    <= 1'b0;
            resp_px_q  <= '0;
            resp_py_q  <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= dt_done;
            case (state)
                IDLE: begin
                    resp_err_q <= 1'b0;
                    if (pick_valid) begin
                        idx_q      <= pick_idx;
                        gnt_q      <= pick_gnt;
                        hold_px    <= sel_px;
                        hold_py    <= sel_py;
                        hold_tm    <= sel_tm;
                        hold_prime <= prime;
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                end
                BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    if (done_edge) begin
                        resp_px_q  <= dt_px_out;
                        resp_py_q  <= dt_py_out;
                        resp_err_q <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_px_q  <= '0;
                        resp_py_q  <= '0;
                        resp_err_q <= 1'b1;
                    end
                end
                RESP: begin
                    rr_ptr <= (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign gnt        = (state != IDLE) ? gnt_q : '0;
    assign resp_valid = (state == RESP) ? gnt_q : '0;
    assign resp_err   = resp_err_q;
    assign resp_px    = resp_px_q;
    assign resp_py    = resp_py_q;
    assign dt_in_sig  = (state == ISSUE);
    assign dt_tomont  = hold_tm;
    assign dt_px      = hold_px;
    assign dt_py      = hold_py;
    assign dt_prime   = hold_prime;

endmodule

// File: tb/tb_dt_arbiter.sv
// tb/tb_dt_arbiter.sv - scoreboard bench for dt_arbiter with a behavioural converter model
module tb_dt_arbiter;
    import ecc_pkg::*;

    localparam int NREQ    = 2;
    localparam int W       = 32;
    localparam int TIMEOUT = 64;
    localparam logic [W-1:0] XK_PX = 32'hA5A5_A5A5;
    localparam logic [W-1:0] XK_PY = 32'h5A5A_5A5A;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_tomont;
    logic [NREQ*W-1:0] req_px;
    logic [NREQ*W-1:0] req_py;
    logic [W-1:0]      prime;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   resp_valid;
    logic              resp_err;
    logic [W-1:0]      resp_px;
    logic [W-1:0]      resp_py;
    logic              dt_in_sig;
    logic              dt_tomont;
    logic [W-1:0]      dt_px;
    logic [W-1:0]      dt_py;
    logic [W-1:0]      dt_prime;
    logic [W-1:0]      dt_px_out = '0;
    logic [W-1:0]      dt_py_out = '0;
    logic              dt_done = 1'b0;

    always #5 clk = ~clk;

    dt_arbiter #(
        .NREQ    (NREQ),
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_tomont (req_tomont),
        .req_px     (req_px),
        .req_py     (req_py),
        .prime      (prime),
        .gnt        (gnt),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_px    (resp_px),
        .resp_py    (resp_py),
        .dt_in_sig  (dt_in_sig),
        .dt_tomont  (dt_tomont),
        .dt_px      (dt_px),
        .dt_py      (dt_py),
        .dt_prime   (dt_prime),
        .dt_px_out  (dt_px_out),
        .dt_py_out  (dt_py_out),
        .dt_done    (dt_done)
    );

    typedef struct {
        int           idx;
        logic         err;
        logic [W-1:0] px;
        logic [W-1:0] py;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic [NREQ-1:0] gnt_log[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int resp_cnt = 0, resp_cyc = 0;
    int in_sig_cnt = 0, in_sig_cyc = 0;
    int rise_cyc = 0;
    int req_cyc = 0;
    int conv_mode = 0;  // 0 real pulse, 1 xor stub with held done level, 2 never done
    logic done_prev = 1'b0;
    logic [NREQ-1:0] gnt_prev = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] to_mont(input logic [W-1:0] x, input logic [W-1:0] p);
        logic [63:0] t;
        t = {x, 32'b0};
        return W'(t % 64'(p));
    endfunction

    function automatic logic [W-1:0] from_mont(input logic [W-1:0] x, input logic [W-1:0] p);
        logic [63:0] t;
        t = 64'(x);
        for (int i = 0; i < 32; i++) begin
            if (t[0]) t = t + 64'(p);
            t = t >> 1;
        end
        return W'(t % 64'(p));
    endfunction

    always @(posedge clk) cyc++;

    // Converter model: latches operands on in_sig, completes DT_LATENCY-ish cycles later.
    logic         cv_busy = 1'b0;
    int           cv_cnt  = 0;
    logic [W-1:0] cv_px = '0, cv_py = '0, cv_p = '0;
    logic         cv_tm = 1'b0;

    always @(posedge clk) begin
        if (dt_in_sig) begin
            cv_busy <= 1'b1;
            cv_cnt  <= 0;
            cv_px   <= dt_px;
            cv_py   <= dt_py;
            cv_p    <= dt_prime;
            cv_tm   <= dt_tomont;
            if (conv_mode != 1) dt_done <= 1'b0;
        end else if (cv_busy) begin
            cv_cnt <= cv_cnt + 1;
            if (cv_cnt == 4) dt_done <= 1'b0;
            if (cv_cnt == DT_LATENCY - 2 && conv_mode != 2) begin
                cv_busy <= 1'b0;
                dt_done <= 1'b1;
                if (conv_mode == 0) begin
                    dt_px_out <= cv_tm ? to_mont(cv_px, cv_p) : from_mont(cv_px, cv_p);
                    dt_py_out <= cv_tm ? to_mont(cv_py, cv_p) : from_mont(cv_py, cv_p);
                end else begin
                    dt_px_out <= cv_px ^ XK_PX;
                    dt_py_out <= cv_py ^ XK_PY;
                end
            end
        end else if (conv_mode == 0) begin
            dt_done <= 1'b0;
        end
    end

    // Response monitor: pops the scoreboard on every resp_valid pulse.
    always @(negedge clk) begin
        if (dt_in_sig) begin
            in_sig_cnt++;
            in_sig_cyc = cyc;
        end
        if (dt_done && !done_prev) rise_cyc = cyc;
        done_prev = dt_done;
        if (gnt != 0 && gnt_prev == 0) gnt_log.push_back(gnt);
        gnt_prev = gnt;
        if (!reset && resp_valid != 0) begin
            resp_cnt++;
            resp_cyc = cyc;
            chk("resp_gnt", 64'(gnt), 64'(resp_valid));
            if (sb.size() == 0) begin
                chk("resp_unexpected", 64'(resp_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_idx", 64'(resp_valid), 64'(1) << e.idx);
                chk("resp_err", 64'(resp_err), 64'(e.err));
                chk("resp_px", 64'(resp_px), 64'(e.px));
                chk("resp_py", 64'(resp_py), 64'(e.py));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_resp(input int n, input int budget, input string tag);
        int t;
        t = 0;
        while (resp_cnt < n && t < budget) begin
            tick();
            t++;
        end
        chk(tag, 64'(resp_cnt), 64'(n));
    endtask

    task automatic wait_in_sig(input int n, input int budget, input string tag);
        int t;
        t = 0;
        while (in_sig_cnt < n && t < budget) begin
            tick();
            t++;
        end
        chk(tag, 64'(in_sig_cnt), 64'(n));
    endtask

    task automatic set_op(input int k, input logic tm, input logic [W-1:0] px, input logic [W-1:0] py);
        req_tomont[k]    = tm;
        req_px[k*W +: W] = px;
        req_py[k*W +: W] = py;
    endtask

    task automatic push(input int k, input logic err, input logic [W-1:0] px, input logic [W-1:0] py);
        exp_t x;
        x.idx = k; x.err = err; x.px = px; x.py = py;
        sb.push_back(x);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a [4];
        logic [W-1:0] b [4];
        int base, ins;

        reset = 1'b1;
        req = '0; req_tomont = '0; req_px = '0; req_py = '0; prime = 32'd23;
        repeat (3) tick();
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_in_sig", 64'(dt_in_sig), 64'd0);
        chk("rst_err", 64'(resp_err), 64'd0);
        chk("rst_resp_px", 64'(resp_px), 64'd0);
        chk("rst_dt_px", 64'(dt_px), 64'd0);
        reset = 1'b0;
        tick();

        // Single to-domain: 5*2^32 mod 23 = 14, 7*2^32 mod 23 = 15.
        set_op(0, 1'b1, 32'h05, 32'h07);
        push(0, 1'b0, 32'h0000_000E, 32'h0000_000F);
        req[0] = 1'b1;
        req_cyc = cyc;
        tick();
        chk("issue_in_sig", 64'(dt_in_sig), 64'd1);
        chk("issue_gnt", 64'(gnt), 64'd1);
        chk("issue_dt_px", 64'(dt_px), 64'h05);
        chk("issue_dt_prime", 64'(dt_prime), 64'd23);
        chk("issue_latency", 64'(in_sig_cyc - req_cyc), 64'd1);
        tick();
        chk("in_sig_one_pulse", 64'(dt_in_sig), 64'd0);
        wait_resp(1, 200, "wait_single");
        req[0] = 1'b0;
        chk("single_in_sig_cnt", 64'(in_sig_cnt), 64'd1);

        // Round trip back out of the Montgomery domain on requester 1.
        set_op(1, 1'b0, 32'h0E, 32'h0F);
        push(1, 1'b0, 32'h05, 32'h07);
        req[1] = 1'b1;
        wait_resp(2, 200, "wait_roundtrip");
        req[1] = 1'b0;

        // Contention from reset: both held, grants must alternate 0,1,0,1.
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            a[i] = 32'($urandom_range(22));
            b[i] = 32'($urandom_range(22));
        end
        set_op(0, 1'b1, a[0], b[0]);
        set_op(1, 1'b0, a[1], b[1]);
        gnt_log.delete();
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push(0, 1'b0, to_mont(a[0], 23), to_mont(b[0], 23));
            else            push(1, 1'b0, from_mont(a[1], 23), from_mont(b[1], 23));
        end
        base = resp_cnt;
        req = 2'b11;
        wait_resp(base + 4, 400, "wait_contention");
        req = 2'b00;
        chk("gnt_log_len", 64'(gnt_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
            chk("gnt_alternate", 64'(gnt_log[i]), (i % 2 == 0) ? 64'd1 : 64'd2);
        end

        // Stale done: converter holds done high between operations.
        conv_mode = 1;
        tick();
        set_op(0, 1'b1, 32'h11, 32'h22);
        push(0, 1'b0, 32'h11 ^ XK_PX, 32'h22 ^ XK_PY);
        base = resp_cnt;
        req[0] = 1'b1;
        wait_resp(base + 1, 200, "wait_stale_a");
        req[0] = 1'b0;
        set_op(1, 1'b0, 32'h33, 32'h44);
        push(1, 1'b0, 32'h33 ^ XK_PX, 32'h44 ^ XK_PY);
        ins = in_sig_cnt;
        req[1] = 1'b1;
        wait_in_sig(ins + 1, 20, "wait_stale_issue");
        repeat (3) tick();
        chk("stale_done_held", 64'(dt_done), 64'd1);
        chk("stale_no_resp", 64'(resp_cnt), 64'(base + 1));
        wait_resp(base + 2, 200, "wait_stale_b");
        req[1] = 1'b0;
        chk("stale_resp_after_edge", 64'(resp_cyc - rise_cyc), 64'd1);

        // Timeout: converter never completes.
        conv_mode = 2;
        tick();
        set_op(0, 1'b1, 32'h09, 32'h0A);
        push(0, 1'b1, 32'h0, 32'h0);
        base = resp_cnt;
        req[0] = 1'b1;
        wait_resp(base + 1, 300, "wait_timeout");
        req[0] = 1'b0;
        chk("timeout_cycles", 64'(resp_cyc - in_sig_cyc), 64'(TIMEOUT + 1));
        tick();
        chk("timeout_idle_gnt", 64'(gnt), 64'd0);
        chk("timeout_idle_valid", 64'(resp_valid), 64'd0);

        // Reset ten cycles into BUSY aborts silently; held req[1] is regranted afterwards.
        conv_mode = 0;
        tick();
        set_op(1, 1'b1, 32'h03, 32'h04);
        ins = in_sig_cnt;
        base = resp_cnt;
        req[1] = 1'b1;
        wait_in_sig(ins + 1, 20, "wait_rst_issue");
        repeat (10) tick();
        reset = 1'b1;
        tick();
        chk("midrst_gnt", 64'(gnt), 64'd0);
        chk("midrst_valid", 64'(resp_valid), 64'd0);
        chk("midrst_in_sig", 64'(dt_in_sig), 64'd0);
        chk("midrst_no_resp", 64'(resp_cnt), 64'(base));
        push(1, 1'b0, to_mont(32'h03, 23), to_mont(32'h04, 23));
        reset = 1'b0;
        tick();
        chk("postrst_gnt", 64'(gnt), 64'd2);
        chk("postrst_in_sig", 64'(dt_in_sig), 64'd1);
        wait_resp(base + 1, 200, "wait_postrst");
        req[1] = 1'b0;

        repeat (3) tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
